inbuf_bank: RTL and testbench
=============================

Name: inbuf_bank

Overview:
Parametrised bank of NPORTS independent input FIFOs for the NoC router. It generalises the fixed five-port (N/S/E/W/L) input buffer stage. Each port receives flits from an upstream link, holds them in a DEPTH-entry circular buffer, and presents the head flit with a non-empty mask to the switch allocator. It also returns per-port credits upstream and flags almost-full for link-level flow control.

Parameters:
NPORTS, 5, number of input ports (port 0 = north, 1 = south, 2 = east, 3 = west, 4 = local at default)
DATA_W, 32, flit width in bits
DEPTH, 8, entries per port FIFO; power of two, >= 2
AF_THRESH, 6, occupancy at or above which almost_full_o asserts; 1..DEPTH

Ports:
clk  in  1  single clock, all state on rising edge
rst  in  1  synchronous active-high reset
data_i  in  NPORTS*DATA_W  incoming flits; port p occupies bits [p*DATA_W +: DATA_W]
valid_i  in  NPORTS  push request per port
pop_req_i  in  NPORTS  pop request per port from switch allocator
data_o  out  NPORTS*DATA_W  head flit per port, same packing as data_i
mask_o  out  NPORTS  1 = port FIFO non-empty (head on data_o is valid)
almost_full_o  out  NPORTS  1 = occupancy >= AF_THRESH
credit_o  out  NPORTS  one-cycle pulse per freed entry, sent upstream
count_o  out  NPORTS*CW  per-port occupancy, CW = $clog2(DEPTH+1)

Behaviour:
- Reset (rst=1 at clock edge): all read/write pointers and counts = 0. mask_o = 0, almost_full_o = 0, credit_o = 0, count_o = 0, data_o = 0. Memory contents are not cleared. Reset asserted mid-stream discards all queued flits and any pending credit pulse.
- The ports are fully independent. No state is shared between ports.
- Push: valid_i[p] & ~full[p] writes data_i slice at wr_ptr, and wr_ptr increments modulo DEPTH (natural wrap, log2(DEPTH) bits).
- Push to full with no pop in the same cycle: flit dropped, state unchanged.
- Pop: pop_req_i[p] & mask_o[p] advances rd_ptr modulo DEPTH. Pop on empty is ignored.
- Simultaneous push+pop on a non-empty port: both take effect and count is unchanged. On a full port, the push is accepted because the pop frees a slot in the same edge.
- Simultaneous push+pop on an empty port: push accepted, pop ignored. The flit becomes visible next cycle.
- Latency: a flit pushed at edge t appears on data_o with mask_o=1 after edge t (visible during cycle t+1). data_o is driven combinationally from memory at rd_ptr and forced to 0 when the port is empty.
- mask_o[p] = (count != 0). almost_full_o[p] = (count >= AF_THRESH). Both are derived from the registered count.
- credit_o[p] is registered: it is high for exactly the one cycle following an accepted pop. Credits never exceed accepted pops.
- count is in range 0..DEPTH at all times. Full = (count == DEPTH).

Optional Feature:
Macro INBUF_ERR_EN.
- Defined: adds output err_o [2*NPORTS-1:0], reset to 0. Bit p is a sticky overflow flag, set by a push dropped at full on port p. Bit NPORTS+p is a sticky underflow flag, set by pop_req_i[p] while the port is empty, except in a same-cycle push on the empty port, which is not flagged. Flags clear only on rst.
- Undefined: port err_o and its logic are absent. Drops and ignored pops are silent.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, inputs 0 -> all outputs 0; count_o=0 for every port.
- Single flit port 2: push 0xDEADBEEF at t -> at t+1 mask_o=5'b00100 and data_o slice 2 = 0xDEADBEEF; pop at t+1 -> credit_o[2]=1 at t+2, mask_o[2]=0, data_o slice 2 = 0.
- Fill and overflow port 0 (DEPTH=8): push 0..8 on consecutive cycles -> count_o slice 0 reaches 8 and almost_full_o[0] rises at count 6. Flit 8 is dropped (err_o[0]=1 with INBUF_ERR_EN). Then 8 pops -> outputs 0..7 in order with 8 credit pulses.
- Wrap-around: on port 4, 20 interleaved push/pop (push+pop same cycle with count=3) -> count stays at 3, FIFO order is preserved across pointer wrap, 20 credit pulses.
- Empty push+pop on port 1: valid_i[1]=1, pop_req_i[1]=1, count=0 -> flit retained, count=1, no credit pulse, err_o[NPORTS+1] stays 0.
- Reset mid-stream: ports 0 and 3 holding 4 flits each, rst pulse -> mask_o=0 and count_o=0 next cycle, no credit pulses issued for the discarded flits.

Source files
------------

// File: rtl/inbuf_bank.sv
// inbuf_bank: a bank of NPORTS independent input FIFOs for the NoC router.
// Each port buffers flits in a DEPTH-entry circular buffer and presents its
// head flit and a non-empty mask to the switch allocator. It also returns
// one credit pulse upstream per freed entry and flags almost-full.
// Optional feature macro: INBUF_ERR_EN adds sticky overflow/underflow flags
// on err_o (bit p = overflow, bit NPORTS+p = underflow).

module inbuf_bank #(
  parameter int NPORTS    = 5,
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = 6
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NPORTS*DATA_W-1:0]            data_i,
  input  logic [NPORTS-1:0]                   valid_i,
  input  logic [NPORTS-1:0]                   pop_req_i,
  output logic [NPORTS*DATA_W-1:0]            data_o,
  output logic [NPORTS-1:0]                   mask_o,
  output logic [NPORTS-1:0]                   almost_full_o,
  output logic [NPORTS-1:0]                   credit_o,
  output logic [NPORTS*$clog2(DEPTH+1)-1:0]   count_o
`ifdef INBUF_ERR_EN
  ,
  output logic [2*NPORTS-1:0]                 err_o
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              credit;
    logic              empty;
    logic              full;
    logic              do_pop;
    logic              do_push;

    // A pop on a full port frees a slot in the same edge, so the push may
    // still be accepted; a pop on an empty port is simply ignored.
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop_req_i[p] & ~empty;
    assign do_push = valid_i[p] & (~full | do_pop);

    // Flit storage; deliberately not cleared on reset.
    always_ff @(posedge clk) begin
      if (do_push) begin
        mem[wr_ptr] <= data_i[p*DATA_W +: DATA_W];
      end
    end

    // Pointer, occupancy and credit state for this port.
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        credit <= 1'b0;
      end else begin
        credit <= do_pop;
        if (do_push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + PW'(1);
        end
        if (do_push && !do_pop) begin
          count <= count + CW'(1);
        end else if (do_pop && !do_push) begin
          count <= count - CW'(1);
        end
      end
    end

    assign data_o[p*DATA_W +: DATA_W] = empty ? '0 : mem[rd_ptr];
    assign mask_o[p]                  = ~empty;
    assign almost_full_o[p]           = (count >= AF_C);
    assign credit_o[p]                = credit;
    assign count_o[p*CW +: CW]        = count;

`ifdef INBUF_ERR_EN
    logic ovf;
    logic udf;

    // Sticky error flags: a push lost at full, or a pop on an empty port
    // that is not rescued by a same-cycle push.
    always_ff @(posedge clk) begin
      if (rst) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (valid_i[p] && !do_push) begin
          ovf <= 1'b1;
        end
        if (pop_req_i[p] && empty && !valid_i[p]) begin
          udf <= 1'b1;
        end
      end
    end

    assign err_o[p]          = ovf;
    assign err_o[NPORTS + p] = udf;
`endif
  end

endmodule

// File: tb/tb_inbuf_bank.sv
// Self-checking bench for inbuf_bank: directed scenarios followed by random
// traffic, compared against a queue-based reference model per port.

module tb_inbuf_bank;

  localparam int NP  = 5;
  localparam int DW  = 32;
  localparam int DEP = 8;
  localparam int AF  = 6;
  localparam int CW  = $clog2(DEP + 1);

  logic                 clk;
  logic                 rst;
  logic [NP*DW-1:0]     data_i;
  logic [NP-1:0]        valid_i;
  logic [NP-1:0]        pop_req_i;
  logic [NP*DW-1:0]     data_o;
  logic [NP-1:0]        mask_o;
  logic [NP-1:0]        almost_full_o;
  logic [NP-1:0]        credit_o;
  logic [NP*CW-1:0]     count_o;
`ifdef INBUF_ERR_EN
  logic [2*NP-1:0]      err_o;
`endif

  inbuf_bank #(
    .NPORTS(NP), .DATA_W(DW), .DEPTH(DEP), .AF_THRESH(AF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .data_i(data_i),
    .valid_i(valid_i),
    .pop_req_i(pop_req_i),
    .data_o(data_o),
    .mask_o(mask_o),
    .almost_full_o(almost_full_o),
    .credit_o(credit_o),
    .count_o(count_o)
`ifdef INBUF_ERR_EN
    ,
    .err_o(err_o)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] model_q [NP][$];
  logic [NP-1:0] exp_credit;
  logic [2*NP-1:0] exp_err;
  bit   checking;
  int   assertions;
  int   failures;

  initial begin
    checking   = 1'b0;
    assertions = 0;
    failures   = 0;
    exp_credit = '0;
    exp_err    = '0;
  end

  task automatic checkOutput(input string name, input int port,
                             input logic [DW-1:0] act, input logic [DW-1:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s port %0d at %0t: got 0x%0h, expected 0x%0h",
               name, port, $time, act, exp);
    end
  endtask

  // Reference model: each port is a bounded queue updated from the inputs
  // presented at the clock edge. Pops are resolved before pushes so that a
  // full port with a pop accepts the push.
  always @(posedge clk) begin
    for (int p = 0; p < NP; p++) begin
      if (rst) begin
        model_q[p].delete();
        exp_credit[p]  = 1'b0;
        exp_err[p]     = 1'b0;
        exp_err[NP+p]  = 1'b0;
      end else begin
        int  sz;
        bit  pop_ok;
        bit  push_ok;
        sz      = model_q[p].size();
        pop_ok  = pop_req_i[p] && (sz > 0);
        push_ok = valid_i[p] && ((sz < DEP) || pop_ok);
        if (valid_i[p] && !push_ok) exp_err[p] = 1'b1;
        if (pop_req_i[p] && (sz == 0) && !valid_i[p]) exp_err[NP+p] = 1'b1;
        if (pop_ok) void'(model_q[p].pop_front());
        if (push_ok) model_q[p].push_back(data_i[p*DW +: DW]);
        exp_credit[p] = pop_ok;
      end
    end
    if (rst) checking = 1'b1;
  end

  // Monitor: on the falling edge compare every port's outputs with the model.
  always @(negedge clk) begin
    if (checking) begin
      for (int p = 0; p < NP; p++) begin
        int sz;
        logic [DW-1:0] head;
        sz   = model_q[p].size();
        head = (sz > 0) ? model_q[p][0] : '0;
        checkOutput("data", p, data_o[p*DW +: DW], head);
        checkOutput("mask", p, DW'(mask_o[p]), DW'(sz != 0));
        checkOutput("count", p, DW'(count_o[p*CW +: CW]), DW'(sz));
        checkOutput("almost_full", p, DW'(almost_full_o[p]), DW'(sz >= AF));
        checkOutput("credit", p, DW'(credit_o[p]), DW'(exp_credit[p]));
`ifdef INBUF_ERR_EN
        checkOutput("err_ovf", p, DW'(err_o[p]), DW'(exp_err[p]));
        checkOutput("err_udf", p, DW'(err_o[NP+p]), DW'(exp_err[NP+p]));
`endif
      end
    end
  end

  function automatic logic [NP*DW-1:0] slot(input int port, input logic [DW-1:0] val);
    logic [NP*DW-1:0] r;
    r = '0;
    r[port*DW +: DW] = val;
    return r;
  endfunction

  // One cycle of stimulus, applied just after the rising edge.
  task automatic applyStimulus(input logic r, input logic [NP-1:0] v,
                               input logic [NP-1:0] pp, input logic [NP*DW-1:0] d);
    @(posedge clk);
    #1;
    rst       = r;
    valid_i   = v;
    pop_req_i = pp;
    data_i    = d;
  endtask

  initial begin
    rst       = 1'b1;
    valid_i   = '0;
    pop_req_i = '0;
    data_i    = '0;

    // Reset then idle.
    applyStimulus(1'b1, '0, '0, '0);
    applyStimulus(1'b1, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, '0);

    // Single flit on port 2, popped the following cycle.
    applyStimulus(1'b0, 5'b00100, '0, slot(2, 32'hDEADBEEF));
    applyStimulus(1'b0, '0, 5'b00100, '0);
    applyStimulus(1'b0, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, '0);

    // Fill port 0 past full, then drain it.
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 5'b00001, '0, slot(0, DW'(i)));
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, '0, 5'b00001, '0);
    applyStimulus(1'b0, '0, '0, '0);
    applyStimulus(1'b0, '0, 5'b00001, '0);

    // Wrap-around on port 4 with steady occupancy of 3.
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 5'b10000, '0, slot(4, 32'h4000 + DW'(i)));
    for (int i = 3; i < 23; i++) applyStimulus(1'b0, 5'b10000, 5'b10000, slot(4, 32'h4000 + DW'(i)));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 5'b10000, '0);
    applyStimulus(1'b0, '0, '0, '0);

    // Push and pop together on empty port 1.
    applyStimulus(1'b0, 5'b00010, 5'b00010, slot(1, 32'hA5A5_0001));
    applyStimulus(1'b0, '0, '0, '0);
    applyStimulus(1'b0, '0, 5'b00010, '0);
    applyStimulus(1'b0, '0, '0, '0);

    // Reset mid-stream with ports 0 and 3 holding 4 flits each.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 5'b01001, '0, slot(0, 32'h100 + DW'(i)) | slot(3, 32'h300 + DW'(i)));
    applyStimulus(1'b1, '0, 5'b01001, '0);
    applyStimulus(1'b0, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, '0);

    // Random traffic on all ports with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      logic [NP-1:0]    v;
      logic [NP-1:0]    pp;
      logic [NP*DW-1:0] d;
      for (int p = 0; p < NP; p++) begin
        v[p]  = ($urandom_range(99) < 55);
        pp[p] = ($urandom_range(99) < 45);
        d[p*DW +: DW] = $urandom;
      end
      applyStimulus(($urandom_range(299) == 0), v, pp, d);
    end
    applyStimulus(1'b0, '0, '0, '0);
    applyStimulus(1'b0, '0, '0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
